bitrev_sequencer: RTL and testbench

BITREV_SEQUENCER -- requirements
Module: bitrev_sequencer

---
 rtl/bitrev_sequencer.sv | 151 +++++++++++++++
 tb/tb_bitrev_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_sequencer.sv
// bitrev_sequencer
//   Reads one frame of N = 2**ADDR_W samples from a synchronous source in
//   ascending address order. Each sample is stored at the bit-reversed index
//   of its address. The frame is then drained in ascending buffer order
//   through a valid/ready output.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       frame request, sampled only in IDLE
//   abort       synchronous cancel of a frame in LOAD or DRAIN
//   src_rd      source read strobe
//   src_addr    source sample index (0 while src_rd is low)
//   src_data    source sample, valid the cycle after src_rd
//   dout        reordered sample (0 while dout_valid is low)
//   dout_valid  dout holds a sample
//   dout_ready  downstream accepts dout
//   busy        high whenever the FSM is not in IDLE
//   done        one-cycle end-of-frame pulse
//   state_dbg   current FSM state, for checkers
//
// Handshake: a sample transfers on every rising edge where
// dout_valid && dout_ready. While dout_valid is high and dout_ready is low,
// dout holds its value. dout_valid does not depend combinationally on
// dout_ready.
module bitrev_sequencer #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // N-1 is the all-ones index.
    localparam logic [ADDR_W-1:0] LAST = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_cnt;   // next source address to read
    logic              rd_active;  // reads still outstanding in LOAD
    logic              cap_valid;  // src_data holds a sample this cycle
    logic [ADDR_W-1:0] cap_addr;   // address that sample was read from
    logic [ADDR_W-1:0] drain_cnt;  // buffer index being presented

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr_cnt  <= '0;
            rd_active <= 1'b0;
            cap_valid <= 1'b0;
            cap_addr  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cap_valid <= 1'b0;
                    if (start) begin
                        state     <= S_LOAD;
                        addr_cnt  <= '0;
                        rd_active <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        addr_cnt  <= '0;
                        rd_active <= 1'b0;
                        cap_valid <= 1'b0;
                    end else begin
                        // Capture pipeline: the read issued this cycle
                        // returns its data next cycle.
                        cap_valid <= rd_active;
                        cap_addr  <= addr_cnt;
                        if (rd_active) begin
                            addr_cnt <= addr_cnt + 1'b1;
                            if (addr_cnt == LAST) begin
                                rd_active <= 1'b0;
                            end
                        end
                        // The last capture is being written this cycle, so
                        // the buffer is complete when DRAIN begins.
                        if (cap_valid && cap_addr == LAST) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        drain_cnt <= '0;
                    end else if (dout_ready) begin
                        drain_cnt <= drain_cnt + 1'b1;
                        if (drain_cnt == LAST) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The buffer needs no reset: DRAIN is only reachable after a full LOAD.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && cap_valid) begin
            mem[bitrev(cap_addr)] <= src_data;
        end
    end

    always_comb begin
        src_rd     = (state == S_LOAD) && rd_active;
        src_addr   = src_rd ? addr_cnt : '0;
        dout_valid = (state == S_DRAIN);
        dout       = dout_valid ? mem[drain_cnt] : '0;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        state_dbg  = state;
    end

endmodule

// File: tb/tb_bitrev_sequencer.sv
module tb_bitrev_sequencer;

  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int N   = 8;
  localparam int AW2 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT (default parameters) ----------------
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          src_rd;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_data = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  bitrev_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- DUT (ADDR_W = 4) ----------------
  logic           start2 = 1'b0;
  logic           abort2 = 1'b0;
  logic           src_rd2;
  logic [AW2-1:0] src_addr2;
  logic [DW-1:0]  src_data2 = '0;
  logic [DW-1:0]  dout2;
  logic           dout_valid2;
  logic           dout_ready2 = 1'b1;
  logic           busy2;
  logic           done2;
  logic [1:0]     state_dbg2;

  bitrev_sequencer #(.ADDR_W(AW2), .DATA_W(DW)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .src_rd(src_rd2), .src_addr(src_addr2), .src_data(src_data2),
    .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready2),
    .busy(busy2), .done(done2), .state_dbg(state_dbg2)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] src_mem [N];
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Mirror of an index over w bits, built arithmetically.
  function automatic int bitrev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  // Source memories: data for a read issued in cycle t is driven just after
  // the edge that ends cycle t and held for all of cycle t+1. Between reads
  // the bus carries random junk.
  initial begin
    logic          rd_s;
    logic [AW-1:0] a_s;
    forever begin
      @(negedge clk);
      rd_s = src_rd;
      a_s  = src_addr;
      @(posedge clk);
      #1;
      src_data = rd_s ? src_mem[a_s] : DW'($urandom);
    end
  end

  initial begin
    logic           rd_s;
    logic [AW2-1:0] a_s;
    forever begin
      @(negedge clk);
      rd_s = src_rd2;
      a_s  = src_addr2;
      @(posedge clk);
      #1;
      src_data2 = rd_s ? DW'(a_s) : DW'($urandom);
    end
  end

  // ---------------- driver / monitor for one frame ----------------
  task automatic run_frame(input bit new_start, input bit hold, input bit noise,
                           input bit idle_abort, input bit rand_rdy,
                           input int stall_k, input int stall_len, input int abort_addr,
                           output int t_start, output int t_valid, output int t_done);
    int rd_idx = 0;
    int acc = 0;
    int stall_cnt = 0;
    bit stalled_prev = 0;
    bit finished = 0;
    bit aborted = 0;
    logic [DW-1:0] prev_dout = '0;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(src_mem[bitrev(k, AW)]);
    t_start = -1;
    t_valid = -1;
    t_done  = -1;
    if (new_start) begin
      @(negedge clk);
      start = 1'b1;
      abort = idle_abort;
      t_start = cyc;
    end
    for (int i = 0; i < 300 && !finished && !aborted; i++) begin
      @(negedge clk);
      abort = 1'b0;
      if (done) start = hold;
      else start = noise ? 1'($urandom_range(0, 1)) : hold;
      if (rand_rdy) dout_ready = ($urandom_range(0, 3) != 0);
      else if (dout_valid && acc == stall_k && stall_cnt < stall_len) begin
        dout_ready = 1'b0;
        stall_cnt++;
      end else dout_ready = 1'b1;
      if (abort_addr >= 0 && src_rd && src_addr == abort_addr) begin
        abort = 1'b1;
        aborted = 1;
      end
      if (!src_rd) check("src_addr_idle", src_addr, 0);
      else begin
        check("src_addr", src_addr, rd_idx);
        rd_idx++;
      end
      if (!dout_valid) begin
        check("dout_idle", dout, 0);
        stalled_prev = 0;
      end else begin
        if (t_valid < 0) t_valid = cyc;
        if (stalled_prev) check("dout_stable", dout, prev_dout);
        check("q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          if (dout_ready) begin
            check("dout", dout, exp_q.pop_front());
            acc++;
            stalled_prev = 0;
          end else begin
            check("dout_stall", dout, exp_q[0]);
            prev_dout = dout;
            stalled_prev = 1;
          end
        end
      end
      if (done) begin
        t_done = cyc;
        check("frame_len", acc, N);
        check("q_empty", exp_q.size(), 0);
        finished = 1;
      end
    end
    if (aborted) begin
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_src_rd", src_rd, 0);
      check("abort_dout_valid", dout_valid, 0);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        check("abort_no_done", done, 0);
        check("abort_stay_idle", busy, 0);
      end
      exp_q.delete();
    end else begin
      check("frame_timeout", finished, 1);
      @(negedge clk);
      start = hold;
      check("done_width", done, 0);
      check("idle_gap", busy, 0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ts, tv, td, d1, d2, d3;
    for (int i = 0; i < N; i++) src_mem[i] = DW'(8'h10 + i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_src_rd", src_rd, 0);
    check("rst_src_addr", src_addr, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, 0);
    check("rst_busy2", busy2, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", busy, 0);

    // Basic frame, ready always high
    run_frame(1, 0, 0, 0, 0, -1, 0, -1, ts, tv, td);
    check("first_valid_cycle", tv - ts, 10);
    check("done_cycle", td - ts, 18);

    // Stall three cycles at k=2
    run_frame(1, 0, 0, 0, 0, 2, 3, -1, ts, tv, td);
    check("stall_first_valid", tv - ts, 10);
    check("stall_done_cycle", td - ts, 21);

    // Abort in LOAD at address 5, then a clean frame
    run_frame(1, 0, 0, 0, 0, -1, 0, 5, ts, tv, td);
    run_frame(1, 0, 0, 0, 0, -1, 0, -1, ts, tv, td);
    check("post_abort_done", td - ts, 18);

    // Abort while in IDLE together with start has no effect
    run_frame(1, 0, 0, 1, 0, -1, 0, -1, ts, tv, td);
    check("idle_abort_done", td - ts, 18);

    // Reset asserted mid-DRAIN between clock edges
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dout_ready = 1'b1;
    for (int w = 0; w < 50 && !dout_valid; w++) @(negedge clk);
    check("drain_reached", dout_valid, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_dout_valid", dout_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_dout", dout, 0);
    check("arst_state", state_dbg, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", done, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_after_done", done, 0);
      check("arst_after_busy", busy, 0);
    end

    // start held for three back-to-back frames
    for (int i = 0; i < N; i++) src_mem[i] = DW'($urandom);
    run_frame(1, 1, 0, 0, 0, -1, 0, -1, ts, tv, d1);
    run_frame(0, 1, 0, 0, 0, -1, 0, -1, ts, tv, d2);
    run_frame(0, 0, 1, 0, 0, -1, 0, -1, ts, tv, d3);
    check("b2b_first_done", d1 - ts, 0 + d1 - ts);
    check("b2b_gap_1", d2 - d1, 19);
    check("b2b_gap_2", d3 - d2, 19);

    // Random data, random backpressure, start noise while busy
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) src_mem[i] = DW'($urandom);
      run_frame(1, 0, 1, 1'($urandom_range(0, 1)), 1, -1, 0, -1, ts, tv, td);
      check("rand_first_valid", tv - ts, 10);
    end

    // ADDR_W = 4 instance: source data equals its index
    begin
      int k = 0;
      bit seen_done = 0;
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 80 && !seen_done; i++) begin
        @(negedge clk);
        if (dout_valid2) begin
          check("aw4_dout", dout2, bitrev(k, AW2));
          k++;
        end
        if (done2) seen_done = 1;
      end
      check("aw4_count", k, 16);
      check("aw4_done", seen_done, 1);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
